// File: rtl/ccd_line_seq.sv
// CCD line sequencer: drives the SH/PH/RS/CP waveforms for one line readout
// and hands each active pixel to the ADC through an adc_req/adc_ack handshake.
module ccd_line_seq #(
    parameter int ELEM_1200 = 10776,
    parameter int ELEM_600  = 5338,
    parameter int DUMMY     = 64,
    parameter int SH_W      = 4,
    parameter int PH_W      = 2,
    parameter int ACK_TO    = 255,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cp_mode,
    input  logic             abort,
    input  logic             adc_ack,
    output logic             SH,
    output logic             PH1A1,
    output logic             PH1A2,
    output logic             PH1B,
    output logic             PH2A1,
    output logic             PH2A2,
    output logic             PHC,
    output logic             RS,
    output logic             CP,
    output logic             adc_req,
    output logic [CNT_W-1:0] pix_idx,
    output logic             busy,
    output logic             line_done,
    output logic             err_timeout
);

    localparam int MAX_ELEM = (ELEM_1200 > ELEM_600) ? ELEM_1200 : ELEM_600;

    if ((64'd1 << CNT_W) <= 64'(DUMMY + MAX_ELEM)) begin : g_cnt_w_check
        $error("CNT_W too small for DUMMY + max element count");
    end
    if (ACK_TO < 1 || ACK_TO > 65535) begin : g_ack_to_check
        $error("ACK_TO out of range 1..65535");
    end

    localparam logic [CNT_W-1:0] DUMMY_C   = CNT_W'(DUMMY);
    localparam logic [CNT_W-1:0] LAST_1200 = CNT_W'(DUMMY + ELEM_1200 - 1);
    localparam logic [CNT_W-1:0] LAST_600  = CNT_W'(DUMMY + ELEM_600 - 1);

    typedef enum logic [2:0] {IDLE, SH_PULSE, PH1, PH2, SAMPLE, LINE_DONE} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      sub_reg, sub_next;
    logic [15:0]      tmr_reg, tmr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] pix_reg, pix_next;
    logic             mode_l_reg, mode_l_next;
    logic             cp_l_reg, cp_l_next;
    logic             err_reg, err_next;

    logic sh_next, rs_next, cp_next, ph1_next, ph2_next, phc_next;
    logic req_next, busy_next, done_next;
    logic ph1_reg, ph2_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pix_next    = pix_reg;
        mode_l_next = mode_l_reg;
        cp_l_next   = cp_l_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next  = SH_PULSE;
                    mode_l_next = mode;
                    cp_l_next   = cp_mode;
                    err_next    = 1'b0;
                    pix_next    = '0;
                    cnt_next    = '0;
                end
            end
            SH_PULSE: if (sub_reg == 16'(SH_W - 1)) state_next = PH1;
            PH1:      if (sub_reg == 16'(PH_W - 1)) state_next = PH2;
            PH2: begin
                if (sub_reg == 16'(PH_W - 1)) begin
                    if (cnt_reg < DUMMY_C) begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = PH1;
                    end else begin
                        pix_next   = cnt_reg - DUMMY_C;
                        state_next = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (adc_ack) begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = (cnt_reg == (mode_l_reg ? LAST_600 : LAST_1200)) ? LINE_DONE : PH1;
                end else if (tmr_reg == 16'(ACK_TO - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            LINE_DONE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (state_reg != IDLE && abort) begin
            state_next = IDLE;
        end
        // Phase sub-counter restarts on every state change; ACK timer only runs in SAMPLE.
        sub_next = (state_next == state_reg) ? sub_reg + 16'd1 : 16'd0;
        tmr_next = (state_reg == SAMPLE) ? tmr_reg + 16'd1 : 16'd0;
    end

    // Output levels for the state being entered, so they line up with state_reg.
    always_comb begin
        sh_next   = 1'b0;
        rs_next   = 1'b0;
        cp_next   = 1'b0;
        ph1_next  = 1'b1;
        ph2_next  = 1'b0;
        phc_next  = mode;
        req_next  = 1'b0;
        busy_next = (state_next != IDLE);
        done_next = 1'b0;
        case (state_next)
            SH_PULSE: sh_next = 1'b1;
            PH1: begin
                rs_next  = 1'b1;
                phc_next = 1'b1;
                cp_next  = cp_l_next || (cnt_next == '0);
            end
            PH2, SAMPLE: begin
                phc_next = 1'b0;
                ph1_next = !mode_l_next;
                ph2_next = mode_l_next;
                req_next = (state_next == SAMPLE);
            end
            LINE_DONE: done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sub_reg    <= '0;
            tmr_reg    <= '0;
            cnt_reg    <= '0;
            pix_reg    <= '0;
            mode_l_reg <= 1'b0;
            cp_l_reg   <= 1'b0;
            err_reg    <= 1'b0;
            SH         <= 1'b0;
            RS         <= 1'b0;
            CP         <= 1'b0;
            ph1_reg    <= 1'b1;
            ph2_reg    <= 1'b0;
            PHC        <= mode;
            adc_req    <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sub_reg    <= sub_next;
            tmr_reg    <= tmr_next;
            cnt_reg    <= cnt_next;
            pix_reg    <= pix_next;
            mode_l_reg <= mode_l_next;
            cp_l_reg   <= cp_l_next;
            err_reg    <= err_next;
            SH         <= sh_next;
            RS         <= rs_next;
            CP         <= cp_next;
            ph1_reg    <= ph1_next;
            ph2_reg    <= ph2_next;
            PHC        <= phc_next;
            adc_req    <= req_next;
            busy       <= busy_next;
            line_done  <= done_next;
        end
    end

    assign PH1A1       = ph1_reg;
    assign PH1A2       = ph1_reg;
    assign PH1B        = ph1_reg;
    assign PH2A1       = ph2_reg;
    assign PH2A2       = ph2_reg;
    assign pix_idx     = pix_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_ccd_line_seq.sv
// Line-level checks of ccd_line_seq: a table of line scenarios with expected
// waveform statistics, plus hand-written reset and idle sequences.
module tb_ccd_line_seq;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n, start, mode, cp_mode, abort, adc_ack;
    logic SH, PH1A1, PH1A2, PH1B, PH2A1, PH2A2, PHC, RS, CP;
    logic adc_req, busy, line_done, err_timeout;
    logic [CNT_W-1:0] pix_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ccd_line_seq #(
        .ELEM_1200(8), .ELEM_600(4), .DUMMY(2), .SH_W(3), .PH_W(2),
        .ACK_TO(5), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cp_mode(cp_mode),
        .abort(abort), .adc_ack(adc_ack),
        .SH(SH), .PH1A1(PH1A1), .PH1A2(PH1A2), .PH1B(PH1B), .PH2A1(PH2A1),
        .PH2A2(PH2A2), .PHC(PHC), .RS(RS), .CP(CP), .adc_req(adc_req),
        .pix_idx(pix_idx), .busy(busy), .line_done(line_done), .err_timeout(err_timeout)
    );

    typedef struct {
        logic mode;
        logic cp;
        logic never_ack;
        logic toggle_cp;
        logic restart;
        int   abort_idx;
        int   exp_sh;
        int   exp_periods;
        int   exp_samples;
        int   exp_max_req;
        int   exp_ld;
        int   exp_to;
        int   exp_cp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({SH, RS, CP, PH1A1, PH1A2, PH1B, PH2A1, PH2A2, PHC, adc_req, busy, line_done});
    endfunction

    function automatic int idle_vec(input logic m);
        return int'({3'b000, 3'b111, 2'b00, m, 3'b000});
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        int sh_c = 0, rs_rises = 0, samples = 0, req_run = 0, max_req = 0;
        int ld_c = 0, cp_rises = 0, phc_falls = 0, ph2_rises = 0;
        int idx_err = 0, lvl_err = 0, rs_run = 0, run_err = 0;
        logic p_rs = 1'b0, p_req = 1'b0, p_cp = 1'b0, p_ph2 = 1'b0, p_phc;
        logic aborted = 1'b0, done = 1'b0;
        p_phc   = v.mode;
        mode    = v.mode;
        cp_mode = v.cp;
        start   = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("v%0d start_busy", n), int'(busy), 1);
                chk($sformatf("v%0d start_err_clr", n), int'(err_timeout), 0);
                chk($sformatf("v%0d start_pix_clr", n), int'(pix_idx), 0);
                start = 1'b0;
            end
            if (c > 0 && !busy) begin
                done = 1'b1;
                chk($sformatf("v%0d end_idle_outs", n), out_vec(), idle_vec(v.mode));
                chk($sformatf("v%0d end_timeout", n), int'(err_timeout), v.exp_to);
            end
            sh_c += int'(SH);
            ld_c += int'(line_done);
            if (RS && !p_rs) rs_rises++;
            if (RS) rs_run++;
            if (!RS && p_rs) begin
                if (rs_run != 2) run_err++;
                rs_run = 0;
            end
            if (CP && !p_cp) cp_rises++;
            if (!PHC && p_phc) phc_falls++;
            if (PH2A1 && !p_ph2) ph2_rises++;
            if (adc_req && !p_req) begin
                if (int'(pix_idx) != samples) idx_err++;
                samples++;
            end
            req_run = adc_req ? req_run + 1 : 0;
            if (req_run > max_req) max_req = req_run;
            if (PH1A1 != PH1A2 || PH1A1 != PH1B || PH2A1 != PH2A2) lvl_err++;
            if (v.mode && PH1A1 == PH2A1) lvl_err++;
            if (!v.mode && (PH2A1 || !PH1A1)) lvl_err++;
            p_rs = RS; p_req = adc_req; p_cp = CP; p_ph2 = PH2A1; p_phc = PHC;
            // Drive inputs for the next rising edge.
            abort   = 1'b0;
            adc_ack = !v.never_ack && adc_req;
            if (v.abort_idx >= 0 && !aborted && adc_req && int'(pix_idx) == v.abort_idx) begin
                abort   = 1'b1;
                adc_ack = 1'b1;
                aborted = 1'b1;
            end
            if (v.toggle_cp) cp_mode = ~cp_mode;
            if (v.restart) start = (c == 15);
        end
        chk($sformatf("v%0d finished", n), int'(done), 1);
        chk($sformatf("v%0d sh_cycles", n), sh_c, v.exp_sh);
        chk($sformatf("v%0d pixel_periods", n), rs_rises, v.exp_periods);
        chk($sformatf("v%0d samples", n), samples, v.exp_samples);
        chk($sformatf("v%0d pix_idx_order", n), idx_err, 0);
        chk($sformatf("v%0d max_req_run", n), max_req, v.exp_max_req);
        chk($sformatf("v%0d line_done", n), ld_c, v.exp_ld);
        chk($sformatf("v%0d cp_pulses", n), cp_rises, v.exp_cp);
        chk($sformatf("v%0d phc_toggles", n), phc_falls, v.exp_periods);
        chk($sformatf("v%0d ph2_pulses", n), ph2_rises, v.mode ? v.exp_periods : 0);
        chk($sformatf("v%0d phase_levels", n), lvl_err, 0);
        chk($sformatf("v%0d ph1_half_len", n), run_err, 0);
        $display("vector %0d: mode=%0d cp=%0d periods=%0d samples=%0d ld=%0d to=%0d",
                 n, v.mode, v.cp, rs_rises, samples, ld_c, err_timeout);
        abort = 1'b0; adc_ack = 1'b0; start = 1'b0; cp_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int wait_c;
        //        mode  cp    never toggle restart abort sh per smp req ld to cp
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3, 10, 8, 1, 1, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3,  6, 4, 1, 1, 0, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3, 10, 8, 1, 1, 0, 10};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 3, 10, 8, 1, 1, 0, 10};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 3,  6, 4, 1, 1, 0, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 3,  3, 1, 5, 0, 1, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  2, 3,  5, 3, 1, 0, 0, 1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3,  6, 4, 1, 1, 0, 6};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; cp_mode = 1'b0; abort = 1'b0; adc_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", out_vec(), idle_vec(1'b0));
        chk("reset_pix_idx", int'(pix_idx), 0);
        chk("reset_err", int'(err_timeout), 0);
        $display("reset: outs=%03h pix_idx=%0d err=%0d", out_vec(), pix_idx, err_timeout);
        rst_n = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        chk("idle_phc_follows_mode", int'(PHC), 1);
        $display("idle: mode=1 PHC=%0d", PHC);
        mode = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Timeout, then reset while idle must clear err_timeout.
        run_vec(vecs[5], 8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_clears_err", int'(err_timeout), 0);
        $display("reset after timeout: err=%0d", err_timeout);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted while waiting in SAMPLE.
        mode = 1'b1; cp_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_c = 0;
        while (!adc_req && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
        end
        chk("reach_sample", int'(adc_req), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midline_reset_outs", out_vec(), idle_vec(1'b1));
        chk("midline_reset_pix", int'(pix_idx), 0);
        chk("midline_reset_err", int'(err_timeout), 0);
        $display("mid-SAMPLE reset: outs=%03h pix_idx=%0d", out_vec(), pix_idx);
        rst_n = 1'b1; mode = 1'b0; cp_mode = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
